// File: rtl/vtail_group_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : vtail_group_writeback
//  Description : Tail-undisturbed group writeback. Walks an LMUL register
//                group one 64-bit beat at a time. For each beat it reads the
//                old destination register, waits for the matching ALU result
//                beat, keeps the old bytes for elements at index >= vl, and
//                writes the merged register back to the VRF.
//  Ports       :
//    clk, rst                     clock, synchronous active-high reset
//    cmd_valid/cmd_ready          group command handshake (ready only in IDLE)
//    cmd_vd, cmd_vl, cmd_vtype    base register, vector length, {vsew,vlmul}
//    res_valid/res_ready/res_data result beat handshake from the vector ALU
//    old_rd_en/addr/data          VRF read of the old destination contents
//                                 (data returns one cycle after the request)
//    wr_en/wr_addr/wr_data        VRF write of the merged register
//    lmul_id                      beats remaining including the current one
//    done, err                    completion / rejection pulses
//  Revision    : 1.0  initial release
// ============================================================================
module vtail_group_writeback #(
    parameter int VLEN = 64,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [$clog2(NREG)-1:0] cmd_vd,
    input  logic [6:0]              cmd_vl,
    input  logic [6:0]              cmd_vtype,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [VLEN-1:0]         res_data,
    output logic                    old_rd_en,
    output logic [$clog2(NREG)-1:0] old_rd_addr,
    input  logic [VLEN-1:0]         old_rd_data,
    output logic                    wr_en,
    output logic [$clog2(NREG)-1:0] wr_addr,
    output logic [VLEN-1:0]         wr_data,
    output logic [3:0]              lmul_id,
    output logic                    done,
    output logic                    err
);

    localparam int       AW       = $clog2(NREG);
    localparam int       NBYTES   = VLEN / 8;
    // Elements per register at SEW=8; shifted right by vsew for wider SEW.
    localparam logic [3:0] EPR_MAX = 4'(VLEN / 8);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_MRG  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_vd;
    logic [6:0]        r_vl;        // effective vl, already clamped to VLMAX
    logic [1:0]        r_vsew;
    logic [3:0]        r_epr;
    logic [3:0]        r_lmul;
    logic [2:0]        r_k;
    logic [VLEN-1:0]   r_old;

    // ------------------------------------------------------------------
    // Command decode (evaluated on the incoming command in IDLE)
    // ------------------------------------------------------------------
    logic [2:0]    w_vsew;
    logic [2:0]    w_vlmul;
    logic [3:0]    w_lmul;
    logic [AW-1:0] w_lmul_mask;
    logic [3:0]    w_epr;
    logic [6:0]    w_vlmax;
    logic [6:0]    w_vl_eff;
    logic          w_bad;
    logic          w_unused_vtype;

    assign w_vsew         = cmd_vtype[5:3];
    assign w_vlmul        = cmd_vtype[2:0];
    assign w_unused_vtype = cmd_vtype[6];
    assign w_lmul         = 4'd1 << w_vlmul[1:0];
    assign w_lmul_mask    = AW'(w_lmul - 4'd1);
    assign w_epr          = EPR_MAX >> w_vsew[1:0];
    assign w_vlmax        = 7'(w_epr) << w_vlmul[1:0];
    assign w_vl_eff       = (cmd_vl < w_vlmax) ? cmd_vl : w_vlmax;
    // Group base must be aligned to LMUL so vd+k never wraps the register file.
    assign w_bad          = (w_vsew > 3'd3) || (w_vlmul > 3'd3) ||
                            ((cmd_vd & w_lmul_mask) != '0);

    // ------------------------------------------------------------------
    // Tail merge for the current beat
    // ------------------------------------------------------------------
    logic [7:0]      w_kepr;
    logic [7:0]      w_vl8;
    logic [7:0]      w_diff;
    logic [7:0]      w_act;
    logic [7:0]      w_nbytes;
    logic [VLEN-1:0] w_merged;

    assign w_kepr   = 8'(r_k) * 8'(r_epr);
    assign w_vl8    = {1'b0, r_vl};
    assign w_diff   = w_vl8 - w_kepr;
    // Active elements in this beat: vl - k*epr clamped into [0, epr].
    assign w_act    = (w_vl8 <= w_kepr)         ? 8'd0 :
                      (w_diff > 8'(r_epr))      ? 8'(r_epr) : w_diff;
    assign w_nbytes = w_act << r_vsew;

    for (genvar b = 0; b < NBYTES; b++) begin : g_byte_merge
        assign w_merged[b*8 +: 8] = (8'(b) < w_nbytes) ? res_data[b*8 +: 8]
                                                       : r_old[b*8 +: 8];
    end

    // The write fires in the same cycle the result beat is accepted, so the
    // write port is a direct function of the MRG handshake. Address and data
    // are zeroed whenever no write is in flight.
    assign wr_en   = res_ready && res_valid;
    assign wr_addr = wr_en ? (r_vd + AW'(r_k)) : '0;
    assign wr_data = wr_en ? w_merged : '0;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vd        <= '0;
            r_vl        <= '0;
            r_vsew      <= '0;
            r_epr       <= '0;
            r_lmul      <= '0;
            r_k         <= '0;
            r_old       <= '0;
            cmd_ready   <= 1'b1;
            res_ready   <= 1'b0;
            old_rd_en   <= 1'b0;
            old_rd_addr <= '0;
            lmul_id     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        r_vd      <= cmd_vd;
                        r_vl      <= w_vl_eff;
                        r_vsew    <= w_vsew[1:0];
                        r_epr     <= w_epr;
                        r_lmul    <= w_lmul;
                        r_k       <= '0;
                        if (w_bad) begin
                            err     <= 1'b1;
                            r_state <= S_FIN;
                        end else if (w_vl_eff == 7'd0) begin
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            lmul_id     <= w_lmul;
                            old_rd_en   <= 1'b1;
                            old_rd_addr <= cmd_vd;
                            r_state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    old_rd_en   <= 1'b0;
                    old_rd_addr <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_old     <= old_rd_data;
                    res_ready <= 1'b1;
                    r_state   <= S_MRG;
                end
                S_MRG: begin
                    if (res_valid) begin
                        res_ready <= 1'b0;
                        if (r_k == 3'(r_lmul - 4'd1)) begin
                            lmul_id <= '0;
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_k         <= r_k + 3'd1;
                            lmul_id     <= lmul_id - 4'd1;
                            old_rd_en   <= 1'b1;
                            old_rd_addr <= r_vd + AW'(r_k) + AW'(1);
                            r_state     <= S_RD;
                        end
                    end
                end
                S_FIN: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    lmul_id   <= '0;
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    cmd_ready <= 1'b1;
                    res_ready <= 1'b0;
                    old_rd_en <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    lmul_id   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
